cnn_layer_accel_fas: RTL and testbench
======================================

Name: cnn_layer_accel_fas

Overview:
- Single-clock feature-accumulation-sum (FAS) job engine for the CNN layer accelerator.
- Host programs a job through a register target port.
- Engine bursts a convolution map and an optional partial map from system memory, adds them lane-wise, writes the sum back, and raises a user interrupt.

Parameters:
PIXEL_WIDTH, 16, signed pixel width
NUM_LANES, 8, pixels per data beat; data width DW = PIXEL_WIDTH*NUM_LANES
ADDR_WIDTH, 32, memory byte-address width
MAX_BEATS, 16, maximum beats per job (local buffer depth)

Ports:
clk_FAS  in  1  sole clock
rst  in  1  asynchronous, active-low reset
targ_write_addr  in  3  register index
targ_write_addr_vld  in  1  register write strobe
targ_write_data  in  32  register write data
targ_write_ack  out  1  write-accept pulse
targ_read_addr  in  3  register index
targ_read_addr_vld  in  1  register read strobe
targ_read_data  out  32  read data
targ_read_ack  out  1  read-data-valid pulse
init_read_req  out  1  read burst request
init_read_req_id  out  1  0 = convMap, 1 = partMap
init_read_addr  out  ADDR_WIDTH  burst start address
init_read_len  out  5  burst length in beats
init_read_req_ack  in  1  request accepted
init_read_data  in  DW  read beat
init_read_data_vld  in  1  beat valid
init_read_data_rdy  out  1  engine ready for beat
init_read_cmpl  in  1  burst complete
init_write_req  out  1  write burst request
init_write_addr  out  ADDR_WIDTH  write address
init_write_len  out  5  beats
init_write_req_ack  in  1  request accepted
init_write_data  out  DW  write beat
init_write_data_vld  out  1  beat valid
init_write_data_rdy  in  1  sink ready
init_write_cmpl  in  1  write complete
init_usrIntr  out  1  job-done interrupt
init_usrIntr_ack  in  1  interrupt acknowledge

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, registers 0, state IDLE, buffer contents don't-care.
- Registers:
  - 0 convMap addr
  - 1 partMap addr
  - 2 output addr
  - 3 length (bits[4:0]; values >MAX_BEATS clamp to MAX_BEATS)
  - 4 control: bit0 start (self-clearing), bit1 partMap enable
  - 5 status (read-only): bit0 busy, bit1 done
- targ_write_ack pulses exactly one cycle after each targ_write_addr_vld. Writes are accepted in any state.
- Register writes during a job do not affect that job: all config is snapshotted when start is accepted.
- Start while busy is ignored.
- Reads: targ_read_data and targ_read_ack are valid one cycle after targ_read_addr_vld. Unmapped indices read 0.
- Register 5 done bit is sticky and clears on the next accepted start.
- FSM: IDLE -> RDC_REQ -> RDC_DAT -> [RDP_REQ -> RDP_DAT if partMap enabled] -> WR_REQ -> WR_DAT -> WR_WAIT -> INTR -> IDLE.
- Length 0: IDLE -> INTR directly, with no memory traffic.
- Request handshake: req, id, addr and len are held stable until the req_ack cycle; req drops the cycle after ack.
- RDC_DAT:
  - init_read_data_rdy = 1.
  - Each beat with vld & rdy is stored to buffer[idx], idx++.
  - Advances after init_read_cmpl and idx == len.
  - Beats beyond len are accepted and discarded.
- RDP_DAT: each accepted beat updates buffer[idx] = buffer[idx] + beat, lane-wise per PIXEL_WIDTH lane. Lanes are independent, with no carry between lanes.
- WR_DAT:
  - Presents buffer[idx] with vld.
  - Advances idx only on vld & rdy.
  - Data is held stable while rdy is low.
  - After len beats, vld drops and the FSM waits for init_write_cmpl.
- INTR:
  - init_usrIntr = 1 until the cycle init_usrIntr_ack is seen.
  - Then done is set, busy clears, and the FSM returns to IDLE.
  - If ack and entry to INTR coincide, init_usrIntr is still asserted for at least one cycle.
- Busy = state != IDLE.
- An asynchronous reset mid-job aborts immediately; no interrupt is raised.

Optional Feature:
- FAS_SATURATE_EN defined: lane add saturates to the signed range, e.g. 0x7FFF + 0x0001 = 0x7FFF and 0x8000 + 0xFFFF = 0x8000.
- Undefined: two's-complement wrap, e.g. 0x7FFF + 0x0001 = 0x8000.

Test Plan:
- Reset: hold rst low 10 cycles -> all outputs 0; status reads 0x0.
- Config: write reg0 = 0x1000 -> targ_write_ack one cycle later; read reg0 returns 0x1000 with targ_read_ack.
- Conv only: len = 4, partMap disabled, conv lanes = 1..8 -> write burst at the reg2 address, len = 4, data identical; then init_usrIntr; status = 0x2 after ack.
- Conv + part: len = 2, lanes 0x0003 + 0x0005 -> output lanes 0x0008.
- Overflow lane: 0x7FFF + 0x0001 -> 0x8000 without FAS_SATURATE_EN, 0x7FFF with it.
- Backpressure/edge:
  - Toggle init_write_data_rdy every cycle -> no lost or duplicated beats.
  - len = 0 -> immediate interrupt, no init_read_req.
  - Start while busy -> ignored.

Source files
------------

// File: rtl/cnn_layer_accel_fas.sv
// cnn_layer_accel_fas: feature-accumulation-sum job engine.
//   A host programs a job through the register target port. The engine bursts
//   a convolution map (and optionally a partial map) from memory, adds them
//   lane-wise into a local buffer, writes the sum back and raises an interrupt.
//
// Ports
//   clk_FAS, rst            : sole clock, asynchronous active-low reset
//   targ_write_* / targ_read_* : register target port (ack one cycle after strobe)
//     0 convMap addr, 1 partMap addr, 2 output addr, 3 length (clamped to MAX_BEATS)
//     4 control (bit0 start self-clearing, bit1 partMap enable), 5 status (bit0 busy, bit1 done)
//   init_read_*             : read burst initiator (id 0 = convMap, 1 = partMap)
//   init_write_*            : write burst initiator
//   init_usrIntr(_ack)      : job-done interrupt handshake
//
// Build option
//   FAS_SATURATE_EN : lane adds saturate to the signed range; otherwise they wrap.

// One signed pixel lane adder.
module fas_lane_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);
`ifdef FAS_SATURATE_EN
  logic [W:0] full;
  assign full = {a[W-1], a} + {b[W-1], b};
  // Overflow when the extended sign disagrees with the result sign.
  always_comb begin
    s = full[W-1:0];
    if (full[W] != full[W-1])
      s = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
`else
  assign s = a + b;
`endif
endmodule

module cnn_layer_accel_fas #(
  parameter int PIXEL_WIDTH = 16,
  parameter int NUM_LANES   = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_BEATS   = 16,
  localparam int DW = PIXEL_WIDTH * NUM_LANES
) (
  input  logic                  clk_FAS,
  input  logic                  rst,
  input  logic [2:0]            targ_write_addr,
  input  logic                  targ_write_addr_vld,
  input  logic [31:0]           targ_write_data,
  output logic                  targ_write_ack,
  input  logic [2:0]            targ_read_addr,
  input  logic                  targ_read_addr_vld,
  output logic [31:0]           targ_read_data,
  output logic                  targ_read_ack,
  output logic                  init_read_req,
  output logic                  init_read_req_id,
  output logic [ADDR_WIDTH-1:0] init_read_addr,
  output logic [4:0]            init_read_len,
  input  logic                  init_read_req_ack,
  input  logic [DW-1:0]         init_read_data,
  input  logic                  init_read_data_vld,
  output logic                  init_read_data_rdy,
  input  logic                  init_read_cmpl,
  output logic                  init_write_req,
  output logic [ADDR_WIDTH-1:0] init_write_addr,
  output logic [4:0]            init_write_len,
  input  logic                  init_write_req_ack,
  output logic [DW-1:0]         init_write_data,
  output logic                  init_write_data_vld,
  input  logic                  init_write_data_rdy,
  input  logic                  init_write_cmpl,
  output logic                  init_usrIntr,
  input  logic                  init_usrIntr_ack
);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [4:0] LEN_MAX = 5'(MAX_BEATS);

  typedef logic [NUM_LANES-1:0][PIXEL_WIDTH-1:0] beat_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] conv;
    logic [ADDR_WIDTH-1:0] part;
    logic [ADDR_WIDTH-1:0] out;
    logic [4:0]            len;
    logic                  pe;
  } job_t;
  typedef enum logic [3:0] {
    IDLE, RDC_REQ, RDC_DAT, RDP_REQ, RDP_DAT, WR_REQ, WR_DAT, WR_WAIT, INTR
  } state_t;

  state_t state;
  job_t   cfg, job;
  logic   done, cmpl_seen;
  logic [4:0] idx, idx_n;
  logic   start_go, beat_take, rd_done, buf_we;
  beat_t  buffer [MAX_BEATS];
  beat_t  buf_rd, buf_nx, rd_beat, sum, buf_wdata;
  logic [31:0] rd_mux;

  // ---------------- register target port ----------------
  assign start_go = targ_write_addr_vld && (targ_write_addr == 3'd4) &&
                    targ_write_data[0] && (state == IDLE);

  always_comb begin
    rd_mux = '0;
    case (targ_read_addr)
      3'd0: rd_mux = 32'(cfg.conv);
      3'd1: rd_mux = 32'(cfg.part);
      3'd2: rd_mux = 32'(cfg.out);
      3'd3: rd_mux = {27'd0, cfg.len};
      3'd4: rd_mux = {30'd0, cfg.pe, 1'b0};
      3'd5: rd_mux = {30'd0, done, (state != IDLE)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_FAS or negedge rst) begin
    if (!rst) begin
      cfg            <= '0;
      targ_write_ack <= 1'b0;
      targ_read_ack  <= 1'b0;
      targ_read_data <= '0;
    end else begin
      targ_write_ack <= targ_write_addr_vld;
      targ_read_ack  <= targ_read_addr_vld;
      if (targ_read_addr_vld) targ_read_data <= rd_mux;
      if (targ_write_addr_vld) begin
        case (targ_write_addr)
          3'd0: cfg.conv <= ADDR_WIDTH'(targ_write_data);
          3'd1: cfg.part <= ADDR_WIDTH'(targ_write_data);
          3'd2: cfg.out  <= ADDR_WIDTH'(targ_write_data);
          3'd3: cfg.len  <= (targ_write_data[4:0] > LEN_MAX) ? LEN_MAX : targ_write_data[4:0];
          3'd4: cfg.pe   <= targ_write_data[1];
          default: ;
        endcase
      end
    end
  end

  // ---------------- datapath ----------------
  assign rd_beat   = init_read_data;
  assign buf_rd    = buffer[idx[BW-1:0]];
  assign buf_nx    = buffer[BW'(idx + 5'd1)];
  // Beats past the job length are still handshaken but never stored.
  assign beat_take = init_read_data_vld && init_read_data_rdy && (idx < job.len);
  assign idx_n     = idx + {4'd0, beat_take};
  assign rd_done   = (cmpl_seen || init_read_cmpl) && (idx_n == job.len);
  assign buf_we    = beat_take && ((state == RDC_DAT) || (state == RDP_DAT));
  assign buf_wdata = (state == RDP_DAT) ? sum : rd_beat;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    fas_lane_add #(.W(PIXEL_WIDTH)) u_add (
      .a(buf_rd[l]),
      .b(rd_beat[l]),
      .s(sum[l])
    );
  end

  always_ff @(posedge clk_FAS) begin
    if (buf_we) buffer[idx[BW-1:0]] <= buf_wdata;
  end

  // ---------------- job FSM ----------------
  always_ff @(posedge clk_FAS or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      job                 <= '0;
      idx                 <= '0;
      cmpl_seen           <= 1'b0;
      done                <= 1'b0;
      init_read_req       <= 1'b0;
      init_read_req_id    <= 1'b0;
      init_read_addr      <= '0;
      init_read_len       <= '0;
      init_read_data_rdy  <= 1'b0;
      init_write_req      <= 1'b0;
      init_write_addr     <= '0;
      init_write_len      <= '0;
      init_write_data     <= '0;
      init_write_data_vld <= 1'b0;
      init_usrIntr        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_go) begin
          // Snapshot config so later register writes cannot disturb this job.
          job.conv  <= cfg.conv;
          job.part  <= cfg.part;
          job.out   <= cfg.out;
          job.len   <= cfg.len;
          job.pe    <= targ_write_data[1];
          done      <= 1'b0;
          idx       <= '0;
          cmpl_seen <= 1'b0;
          if (cfg.len == 5'd0) begin
            state        <= INTR;
            init_usrIntr <= 1'b1;
          end else begin
            state            <= RDC_REQ;
            init_read_req    <= 1'b1;
            init_read_req_id <= 1'b0;
            init_read_addr   <= cfg.conv;
            init_read_len    <= cfg.len;
          end
        end
        RDC_REQ, RDP_REQ: if (init_read_req_ack) begin
          init_read_req      <= 1'b0;
          init_read_data_rdy <= 1'b1;
          idx                <= '0;
          cmpl_seen          <= 1'b0;
          state              <= (state == RDC_REQ) ? RDC_DAT : RDP_DAT;
        end
        RDC_DAT, RDP_DAT: begin
          idx <= idx_n;
          if (init_read_cmpl) cmpl_seen <= 1'b1;
          if (rd_done) begin
            init_read_data_rdy <= 1'b0;
            idx                <= '0;
            cmpl_seen          <= 1'b0;
            if ((state == RDC_DAT) && job.pe) begin
              state            <= RDP_REQ;
              init_read_req    <= 1'b1;
              init_read_req_id <= 1'b1;
              init_read_addr   <= job.part;
              init_read_len    <= job.len;
            end else begin
              state           <= WR_REQ;
              init_write_req  <= 1'b1;
              init_write_addr <= job.out;
              init_write_len  <= job.len;
            end
          end
        end
        WR_REQ: if (init_write_req_ack) begin
          // idx is 0 here, so buf_rd is the first beat.
          init_write_req      <= 1'b0;
          init_write_data     <= buf_rd;
          init_write_data_vld <= 1'b1;
          cmpl_seen           <= 1'b0;
          state               <= WR_DAT;
        end
        WR_DAT: begin
          if (init_write_cmpl) cmpl_seen <= 1'b1;
          if (init_write_data_vld && init_write_data_rdy) begin
            idx <= idx + 5'd1;
            if ((idx + 5'd1) == job.len) begin
              init_write_data_vld <= 1'b0;
              state               <= WR_WAIT;
            end else begin
              init_write_data <= buf_nx;
            end
          end
        end
        WR_WAIT: if (cmpl_seen || init_write_cmpl) begin
          cmpl_seen    <= 1'b0;
          init_usrIntr <= 1'b1;
          state        <= INTR;
        end
        INTR: if (init_usrIntr_ack) begin
          init_usrIntr <= 1'b0;
          done         <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_layer_accel_fas.sv
// Bench for cnn_layer_accel_fas: memory read/write responders, scoreboard of
// expected write beats filled when read data is prepared.
module tb_cnn_layer_accel_fas;
  localparam int PW = 16;
  localparam int NL = 8;
  localparam int DW = PW * NL;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    targ_write_addr, targ_read_addr;
  logic          targ_write_addr_vld, targ_read_addr_vld;
  logic [31:0]   targ_write_data, targ_read_data;
  logic          targ_write_ack, targ_read_ack;
  logic          init_read_req, init_read_req_id, init_read_req_ack;
  logic [AW-1:0] init_read_addr, init_write_addr;
  logic [4:0]    init_read_len, init_write_len;
  logic [DW-1:0] init_read_data, init_write_data;
  logic          init_read_data_vld, init_read_data_rdy, init_read_cmpl;
  logic          init_write_req, init_write_req_ack;
  logic          init_write_data_vld, init_write_data_rdy, init_write_cmpl;
  logic          init_usrIntr, init_usrIntr_ack;

  always #5 clk = ~clk;

  cnn_layer_accel_fas #(.PIXEL_WIDTH(PW), .NUM_LANES(NL), .ADDR_WIDTH(AW), .MAX_BEATS(16)) dut (
    .clk_FAS(clk), .rst(rst),
    .targ_write_addr(targ_write_addr), .targ_write_addr_vld(targ_write_addr_vld),
    .targ_write_data(targ_write_data), .targ_write_ack(targ_write_ack),
    .targ_read_addr(targ_read_addr), .targ_read_addr_vld(targ_read_addr_vld),
    .targ_read_data(targ_read_data), .targ_read_ack(targ_read_ack),
    .init_read_req(init_read_req), .init_read_req_id(init_read_req_id),
    .init_read_addr(init_read_addr), .init_read_len(init_read_len),
    .init_read_req_ack(init_read_req_ack), .init_read_data(init_read_data),
    .init_read_data_vld(init_read_data_vld), .init_read_data_rdy(init_read_data_rdy),
    .init_read_cmpl(init_read_cmpl),
    .init_write_req(init_write_req), .init_write_addr(init_write_addr),
    .init_write_len(init_write_len), .init_write_req_ack(init_write_req_ack),
    .init_write_data(init_write_data), .init_write_data_vld(init_write_data_vld),
    .init_write_data_rdy(init_write_data_rdy), .init_write_cmpl(init_write_cmpl),
    .init_usrIntr(init_usrIntr), .init_usrIntr_ack(init_usrIntr_ack)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] conv_mem [32];
  logic [DW-1:0] part_mem [32];
  logic [AW-1:0] exp_conv, exp_part, exp_out;
  logic [4:0]    exp_len;
  bit            wr_toggle = 1'b0;
  int            extra = 0;
  int            rd_req_cnt = 0;
  int            wr_burst_cnt = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference lane add: signed sum, wrapped or clamped to the pixel range.
  function automatic logic [DW-1:0] fas_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      s = int'($signed(a[l*PW +: PW])) + int'($signed(b[l*PW +: PW]));
`ifdef FAS_SATURATE_EN
      if (s > (1 << (PW-1)) - 1) s = (1 << (PW-1)) - 1;
      if (s < -(1 << (PW-1)))    s = -(1 << (PW-1));
`endif
      r[l*PW +: PW] = s[PW-1:0];
    end
    return r;
  endfunction

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    targ_write_addr = a; targ_write_data = d; targ_write_addr_vld = 1'b1;
    @(negedge clk);
    targ_write_addr_vld = 1'b0;
    chk("wr_ack", DW'(targ_write_ack), DW'(1));
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
    targ_read_addr = a; targ_read_addr_vld = 1'b1;
    @(negedge clk);
    targ_read_addr_vld = 1'b0;
    chk("rd_ack", DW'(targ_read_ack), DW'(1));
    d = targ_read_data;
  endtask

  task automatic wait_intr();
    int cyc = 0;
    while (!init_usrIntr && cyc < 2000) begin
      @(negedge clk); cyc++;
    end
    chk("intr_seen", DW'(init_usrIntr), DW'(1));
    init_usrIntr_ack = 1'b1;
    @(negedge clk);
    init_usrIntr_ack = 1'b0;
    chk("intr_clr", DW'(init_usrIntr), DW'(0));
  endtask

  // Read memory responder: ack request, stream len(+extra) beats, then cmpl.
  initial begin
    logic id; logic [4:0] ln; int b, cyc; logic r;
    init_read_req_ack = 0; init_read_data = '0; init_read_data_vld = 0; init_read_cmpl = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && init_read_req) begin
        id = init_read_req_id; ln = init_read_len;
        chk(id ? "rd_addr_part" : "rd_addr_conv", DW'(init_read_addr), DW'(id ? exp_part : exp_conv));
        chk("rd_len", DW'(ln), DW'(exp_len));
        rd_req_cnt++;
        init_read_req_ack = 1'b1;
        @(negedge clk);
        init_read_req_ack = 1'b0;
        b = 0; cyc = 0;
        while (b < int'(ln) + extra && cyc < 500) begin
          init_read_data = (b < int'(ln)) ? (id ? part_mem[b] : conv_mem[b])
                                          : {$urandom, $urandom, $urandom, $urandom};
          init_read_data_vld = 1'b1;
          r = init_read_data_rdy;
          @(negedge clk); cyc++;
          if (r) b++;
        end
        chk("rd_beats_sent", DW'(b), DW'(int'(ln) + extra));
        init_read_data_vld = 1'b0; init_read_cmpl = 1'b1;
        @(negedge clk);
        init_read_cmpl = 1'b0;
      end
    end
  end

  // Write memory responder: ack request, consume beats against the scoreboard.
  initial begin
    logic [4:0] ln; int cnt, cyc; logic [DW-1:0] ex;
    init_write_req_ack = 0; init_write_data_rdy = 0; init_write_cmpl = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && init_write_req) begin
        chk("wr_addr", DW'(init_write_addr), DW'(exp_out));
        chk("wr_len", DW'(init_write_len), DW'(exp_len));
        wr_burst_cnt++;
        ln = init_write_len;
        init_write_req_ack = 1'b1;
        @(negedge clk);
        init_write_req_ack = 1'b0;
        init_write_data_rdy = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < int'(ln) && cyc < 500) begin
          init_write_data_rdy = wr_toggle ? ~init_write_data_rdy : 1'b1;
          if (init_write_data_vld && init_write_data_rdy) begin
            if (exp_q.size() > 0) ex = exp_q.pop_front();
            else ex = 'x;
            chk("wr_data", init_write_data, ex);
            cnt++;
          end
          @(negedge clk); cyc++;
        end
        chk("wr_beats", DW'(cnt), DW'(ln));
        chk("wr_vld_drop", DW'(init_write_data_vld), DW'(0));
        init_write_data_rdy = 1'b0; init_write_cmpl = 1'b1;
        @(negedge clk);
        init_write_cmpl = 1'b0;
      end
    end
  end

  // mode 0: lanes b*8+l+1, 1: 3+5, 2: overflow corners, 3: random.
  task automatic run_job(input int jn, input int len, input bit pe, input int mode,
                         input bit tog, input int xtra, input bit poke);
    logic [31:0] d; int r0, w0;
    for (int b = 0; b < len; b++) begin
      for (int l = 0; l < NL; l++) begin
        case (mode)
          0: begin conv_mem[b][l*PW +: PW] = PW'(b*8 + l + 1); part_mem[b][l*PW +: PW] = '0; end
          1: begin conv_mem[b][l*PW +: PW] = 16'h0003; part_mem[b][l*PW +: PW] = 16'h0005; end
          default: begin
            conv_mem[b][l*PW +: PW] = PW'($urandom); part_mem[b][l*PW +: PW] = PW'($urandom);
          end
        endcase
      end
      if (mode == 2) begin
        conv_mem[b][0*PW +: PW] = 16'h7FFF; part_mem[b][0*PW +: PW] = 16'h0001;
        conv_mem[b][1*PW +: PW] = 16'h8000; part_mem[b][1*PW +: PW] = 16'hFFFF;
        conv_mem[b][2*PW +: PW] = 16'h1234; part_mem[b][2*PW +: PW] = 16'hFFFF;
      end
      exp_q.push_back(pe ? fas_add(conv_mem[b], part_mem[b]) : conv_mem[b]);
    end
    exp_conv = 32'h1000 + 32'(jn) * 32'h100;
    exp_part = 32'h2000 + 32'(jn) * 32'h100;
    exp_out  = 32'h3000 + 32'(jn) * 32'h100;
    exp_len  = 5'(len);
    wr_toggle = tog; extra = xtra;
    wr_reg(3'd0, exp_conv); wr_reg(3'd1, exp_part); wr_reg(3'd2, exp_out); wr_reg(3'd3, 32'(len));
    r0 = rd_req_cnt; w0 = wr_burst_cnt;
    wr_reg(3'd4, {30'd0, pe, 1'b1});
    if (poke) begin
      rd_reg(3'd5, d);
      chk("busy_status", DW'(d), DW'(1));
      wr_reg(3'd2, 32'h9999);
      wr_reg(3'd4, 32'h1);
    end
    wait_intr();
    rd_reg(3'd5, d);
    chk("done_status", DW'(d), DW'(2));
    chk("rd_req_count", DW'(rd_req_cnt - r0), DW'(len == 0 ? 0 : (pe ? 2 : 1)));
    chk("wr_burst_count", DW'(wr_burst_cnt - w0), DW'(len == 0 ? 0 : 1));
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b0;
    targ_write_addr = '0; targ_write_addr_vld = 0; targ_write_data = '0;
    targ_read_addr = '0; targ_read_addr_vld = 0; init_usrIntr_ack = 0;
    repeat (10) @(negedge clk);
    chk("rst_ctl", DW'({init_read_req, init_read_req_id, init_read_addr, init_read_len,
                        init_read_data_rdy, init_write_req, init_write_addr, init_write_len,
                        init_write_data_vld, init_usrIntr, targ_write_ack, targ_read_ack}), '0);
    chk("rst_rdata", DW'(targ_read_data), '0);
    chk("rst_wdata", init_write_data, '0);
    rst = 1'b1;
    @(negedge clk);
    rd_reg(3'd5, d);
    chk("status_reset", DW'(d), DW'(0));

    wr_reg(3'd0, 32'h1000);
    @(negedge clk);
    chk("wr_ack_pulse", DW'(targ_write_ack), DW'(0));
    rd_reg(3'd0, d);
    chk("reg0_rb", DW'(d), DW'(32'h1000));
    wr_reg(3'd3, 32'd20);
    rd_reg(3'd3, d);
    chk("len_clamp", DW'(d), DW'(16));
    rd_reg(3'd7, d);
    chk("unmapped_rd", DW'(d), DW'(0));

    run_job(0, 4, 1'b0, 0, 1'b0, 0, 1'b0);  // conv only
    run_job(1, 2, 1'b1, 1, 1'b0, 1, 1'b0);  // conv + part, one surplus beat per burst
    run_job(2, 1, 1'b1, 2, 1'b0, 0, 1'b0);  // lane overflow corners
    run_job(3, 5, 1'b1, 3, 1'b1, 0, 1'b0);  // random with write backpressure
    run_job(4, 4, 1'b0, 3, 1'b1, 0, 1'b1);  // start + config writes while busy
    init_usrIntr_ack = 1'b1;                // ack already high on INTR entry
    run_job(5, 0, 1'b0, 0, 1'b0, 0, 1'b0);  // zero length

    chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
